// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Fetch-side producer for the fetch-to-decode pipeline register. It owns the
// PC and issues requests to instruction memory over a valid/ready channel.
// Memory latency may vary, and only one request is outstanding at a time.
// Redirects from Execute replace the PC. A response that belongs to a request
// issued before a redirect is discarded.
//
// Ports
//   CLK, RST_N        clock; asynchronous active-low reset
//   StallF            hazard hold: keep the current instruction, do not advance
//   PCSrcE, PCTargetE redirect request and target from Execute
//   IMemReqValid/Addr request channel out (address is always PCF)
//   IMemReqReady      memory accepts the request
//   IMemRespValid/Data response channel in
//   RD                instruction to decode (0 when InstrValidF=0)
//   PCF, PCPlus4F     current fetch PC and PC+4 (wraps modulo 2^DATA_WIDTH)
//   InstrValidF       RD holds a valid instruction for PCF
//   FetchBusy         !InstrValidF; hazard unit inserts a bubble while high
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  StallF,
    input  logic                  PCSrcE,
    input  logic [DATA_WIDTH-1:0] PCTargetE,
    output logic                  IMemReqValid,
    output logic [DATA_WIDTH-1:0] IMemReqAddr,
    input  logic                  IMemReqReady,
    input  logic                  IMemRespValid,
    input  logic [DATA_WIDTH-1:0] IMemRespData,
    output logic [DATA_WIDTH-1:0] RD,
    output logic [DATA_WIDTH-1:0] PCF,
    output logic [DATA_WIDTH-1:0] PCPlus4F,
    output logic                  InstrValidF,
    output logic                  FetchBusy
);

    // REQ : request presented, waiting for acceptance
    // WAIT: request accepted, response owed for the current PC
    // HOLD: instruction buffered, decode is stalled
    // DROP: response owed for a PC that a redirect has replaced
    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DROP
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] buf_q, buf_d;
    logic [DATA_WIDTH-1:0] pc_plus4;

    assign pc_plus4 = pc_q + DATA_WIDTH'(4);

    // NOTE: state registers take non-blocking assignments only, so every flop
    // samples the values from before the edge regardless of statement order.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            // NOTE: the instruction buffer is a single register, not a RAM,
            // so clearing it on reset is cheap and keeps RD deterministic.
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            buf_q   <= buf_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default before the case, so
        // no path through it can leave a signal unassigned and infer a latch.
        state_d      = state_q;
        pc_d         = pc_q;
        buf_d        = buf_q;
        IMemReqValid = 1'b0;
        InstrValidF  = 1'b0;
        RD           = '0;

        unique case (state_q)
            S_REQ: begin
                IMemReqValid = 1'b1;
                // An acceptance in the same cycle as a redirect still leaves a
                // response owed, and that response is now stale.
                if (IMemReqReady) begin
                    state_d = PCSrcE ? S_DROP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (PCSrcE) begin
                    // A response in this cycle is for the old PC: discard it.
                    state_d = IMemRespValid ? S_REQ : S_DROP;
                end else if (IMemRespValid) begin
                    InstrValidF = 1'b1;
                    RD          = IMemRespData;
                    buf_d       = IMemRespData;
                    if (StallF) begin
                        state_d = S_HOLD;
                    end else begin
                        pc_d    = pc_plus4;
                        state_d = S_REQ;
                    end
                end
            end
            S_HOLD: begin
                InstrValidF = 1'b1;
                RD          = buf_q;
                if (PCSrcE) begin
                    state_d = S_REQ;
                end else if (!StallF) begin
                    pc_d    = pc_plus4;
                    state_d = S_REQ;
                end
            end
            S_DROP: begin
                // Only one response is ever owed, so further redirects here
                // just update the PC and keep waiting for it.
                if (IMemRespValid) begin
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase

        // A redirect overrides any increment chosen above.
        if (PCSrcE) begin
            pc_d = PCTargetE;
        end
    end

    assign IMemReqAddr = pc_q;
    assign PCF         = pc_q;
    assign PCPlus4F    = pc_plus4;
    assign FetchBusy   = ~InstrValidF;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed scenarios followed by a randomized run. A behavioural model tracks
// the fetch unit as a few flags: a request is in flight, the in-flight
// response is stale, and an instruction is held. A variable-latency memory
// model drives the response channel.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam int          DW       = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          StallF;
    logic          PCSrcE;
    logic [DW-1:0] PCTargetE;
    logic          IMemReqValid;
    logic [DW-1:0] IMemReqAddr;
    logic          IMemReqReady;
    logic          IMemRespValid;
    logic [DW-1:0] IMemRespData;
    logic [DW-1:0] RD;
    logic [DW-1:0] PCF;
    logic [DW-1:0] PCPlus4F;
    logic          InstrValidF;
    logic          FetchBusy;

    fetch_unit #(.DATA_WIDTH(DW), .RESET_PC(RESET_PC)) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .StallF       (StallF),
        .PCSrcE       (PCSrcE),
        .PCTargetE    (PCTargetE),
        .IMemReqValid (IMemReqValid),
        .IMemReqAddr  (IMemReqAddr),
        .IMemReqReady (IMemReqReady),
        .IMemRespValid(IMemRespValid),
        .IMemRespData (IMemRespData),
        .RD           (RD),
        .PCF          (PCF),
        .PCPlus4F     (PCPlus4F),
        .InstrValidF  (InstrValidF),
        .FetchBusy    (FetchBusy)
    );

    always #5 CLK = ~CLK;

    int n_total = 0;
    int n_pass  = 0;

    // stimulus knobs
    logic        s_stall, s_pcsrc, s_ready, s_spurious;
    logic [31:0] s_target;
    int          s_lat;

    // behavioural model of the fetch unit
    logic [31:0] m_pc;
    logic        m_pending;   // a request is in flight
    logic        m_stale;     // its response belongs to a replaced PC
    logic        m_held;      // an instruction is held under stall
    logic [31:0] m_held_data;

    // memory model
    logic        mem_busy;
    int          mem_cnt;
    logic [31:0] mem_addr;

    // per-cycle values shared between drive_check and advance
    logic        c_resp_valid;
    logic [31:0] c_resp_data;
    logic        e_req;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] h;
        h = {a[15:0] ^ 16'h5A3C, a[31:16]} ^ 32'h0000_0013;
        return (a == 32'h0) ? 32'h0050_0093 : h;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    task automatic model_reset();
        m_pc        = RESET_PC;
        m_pending   = 1'b0;
        m_stale     = 1'b0;
        m_held      = 1'b0;
        m_held_data = '0;
        mem_busy    = 1'b0;
        mem_cnt     = 0;
        mem_addr    = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pcf"},   PCF,                 RESET_PC);
        check({tag, "_valid"}, {31'b0, InstrValidF}, 32'd0);
        check({tag, "_rd"},    RD,                  32'd0);
        check({tag, "_busy"},  {31'b0, FetchBusy},  32'd1);
        check({tag, "_req"},   {31'b0, IMemReqValid}, 32'd1);
    endtask

    // Called at the falling edge: drive inputs, let them settle, compare all
    // outputs with the model's view of this cycle.
    task automatic drive_check();
        logic        fresh, e_valid;
        logic [31:0] e_rd;
        if (mem_busy && mem_cnt == 0) begin
            c_resp_valid = 1'b1;
            c_resp_data  = mem_word(mem_addr);
        end else begin
            c_resp_valid = !mem_busy && s_spurious;
            c_resp_data  = $urandom;
        end
        StallF        = s_stall;
        PCSrcE        = s_pcsrc;
        PCTargetE     = s_target;
        IMemReqReady  = s_ready;
        IMemRespValid = c_resp_valid;
        IMemRespData  = c_resp_data;
        #1;
        e_req   = !m_pending && !m_held;
        fresh   = m_pending && c_resp_valid && !m_stale && !s_pcsrc;
        e_valid = fresh || m_held;
        e_rd    = fresh ? c_resp_data : (m_held ? m_held_data : 32'd0);
        check("req_valid", {31'b0, IMemReqValid}, {31'b0, e_req});
        check("req_addr",  IMemReqAddr,           m_pc);
        check("pcf",       PCF,                   m_pc);
        check("pcplus4",   PCPlus4F,              m_pc + 32'd4);
        check("valid",     {31'b0, InstrValidF},  {31'b0, e_valid});
        check("busy",      {31'b0, FetchBusy},    {31'b0, !e_valid});
        check("rd",        RD,                    e_rd);
    endtask

    // Update model and memory for the coming rising edge, then move to the
    // next falling edge.
    task automatic advance();
        logic        accepted, resp_here;
        logic [31:0] n_pc;
        logic        n_pending, n_stale, n_held;
        logic [31:0] n_held_data;
        accepted    = e_req && s_ready;
        resp_here   = m_pending && c_resp_valid;
        n_pc        = m_pc;
        n_pending   = m_pending;
        n_stale     = m_stale;
        n_held      = m_held;
        n_held_data = m_held_data;
        if (s_pcsrc) begin
            n_pc      = s_target;
            n_held    = 1'b0;
            n_pending = accepted || (m_pending && !resp_here);
            n_stale   = n_pending;
        end else if (accepted) begin
            n_pending = 1'b1;
            n_stale   = 1'b0;
        end else if (resp_here) begin
            n_pending = 1'b0;
            n_stale   = 1'b0;
            if (!m_stale) begin
                if (s_stall) begin
                    n_held      = 1'b1;
                    n_held_data = c_resp_data;
                end else begin
                    n_pc = m_pc + 32'd4;
                end
            end
        end else if (m_held && !s_stall) begin
            n_held = 1'b0;
            n_pc   = m_pc + 32'd4;
        end
        @(posedge CLK);
        m_pc        = n_pc;
        m_pending   = n_pending;
        m_stale     = n_stale;
        m_held      = n_held;
        m_held_data = n_held_data;
        if (accepted) begin
            mem_busy = 1'b1;
            mem_addr = IMemReqAddr === m_pc ? mem_addr : mem_addr;
            mem_cnt  = s_lat - 1;
        end else if (mem_busy) begin
            if (mem_cnt == 0) mem_busy = 1'b0;
            else mem_cnt--;
        end
        @(negedge CLK);
    endtask

    task automatic cycle();
        drive_check();
        advance();
    endtask

    initial begin
        RST_N = 1'b0;
        StallF = 1'b0; PCSrcE = 1'b0; PCTargetE = '0;
        IMemReqReady = 1'b0; IMemRespValid = 1'b0; IMemRespData = '0;
        s_stall = 1'b0; s_pcsrc = 1'b0; s_ready = 1'b1; s_spurious = 1'b0;
        s_target = '0; s_lat = 1;
        model_reset();
        repeat (2) @(negedge CLK);
        check_reset_outputs("reset");
        RST_N = 1'b1;

        // Boot fetch from RESET_PC with a one-cycle memory.
        drive_check();
        check("boot_addr", IMemReqAddr, 32'h0);
        mem_addr = m_pc; advance();
        drive_check();
        check("boot_valid", {31'b0, InstrValidF}, 32'd1);
        check("boot_rd", RD, 32'h0050_0093);
        advance();
        check("boot_pcf", PCF, 32'h4);
        check("boot_pcplus4", PCPlus4F, 32'h8);

        // Stall while the response for PC 4 arrives.
        mem_addr = m_pc; cycle();
        s_stall = 1'b1;
        cycle();
        repeat (3) begin
            drive_check();
            check("hold_rd", RD, mem_word(32'h4));
            check("hold_pcf", PCF, 32'h4);
            advance();
        end
        s_stall = 1'b0;
        cycle();
        check("release_pcf", PCF, 32'h8);

        // Redirect while waiting on a three-cycle response.
        s_lat = 3;
        drive_check();
        check("rerequest", {31'b0, IMemReqValid}, 32'd1);
        mem_addr = m_pc; advance();
        s_pcsrc = 1'b1; s_target = 32'h40;
        cycle();
        s_pcsrc = 1'b0;
        check("redirect_pcf", PCF, 32'h40);
        cycle();
        drive_check();
        check("stale_dropped", {31'b0, InstrValidF}, 32'd0);
        advance();
        s_lat = 1;
        drive_check();
        check("redirect_addr", IMemReqAddr, 32'h40);
        mem_addr = m_pc; advance();

        // Redirect in the same cycle as the response.
        s_pcsrc = 1'b1; s_target = 32'h80;
        drive_check();
        check("coincident_valid", {31'b0, InstrValidF}, 32'd0);
        advance();
        s_pcsrc = 1'b0;
        check("coincident_pcf", PCF, 32'h80);

        // Backpressure: request held with a stable address.
        s_ready = 1'b0;
        repeat (4) begin
            drive_check();
            check("bp_addr", IMemReqAddr, 32'h80);
            advance();
        end
        s_ready = 1'b1;
        mem_addr = m_pc; cycle();
        cycle();

        // Wrap at the top of the address space.
        s_ready = 1'b0; s_pcsrc = 1'b1; s_target = 32'hFFFF_FFFC;
        cycle();
        s_ready = 1'b1; s_pcsrc = 1'b0;
        check("wrap_pcplus4", PCPlus4F, 32'h0);
        mem_addr = m_pc; cycle();
        cycle();
        check("wrap_pcf", PCF, 32'h0);

        // Asynchronous reset while a response is owed.
        s_lat = 3;
        mem_addr = m_pc; cycle();
        #2 RST_N = 1'b0;
        #1 check_reset_outputs("async");
        model_reset();
        @(negedge CLK);
        RST_N = 1'b1;
        s_lat = 1;
        drive_check();
        check("restart_addr", IMemReqAddr, RESET_PC);
        mem_addr = m_pc; advance();

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            s_stall    = ($urandom_range(0, 9) < 3);
            s_pcsrc    = ($urandom_range(0, 9) == 0);
            s_target   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 + {$urandom_range(0, 1), 2'b00}
                                                     : {$urandom_range(0, 255), 2'b00};
            s_ready    = ($urandom_range(0, 9) < 7);
            s_spurious = ($urandom_range(0, 4) == 0);
            s_lat      = $urandom_range(1, 3);
            mem_addr   = (!mem_busy) ? m_pc : mem_addr;
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
